noc_packetizer: RTL and testbench

Clocked network-interface stage that sits directly upstream of a tree-router child input port. It accepts destination/payload requests from a processing element and formats each one into a 32-bit packet stamped with its own source address. Packets are buffered in a small FIFO and presented to the router input through a valid/ready handshake. It decouples PE issue rate from router back-pressure.

---
 rtl/noc_packetizer_if.sv | 30 +++
 rtl/noc_packetizer.sv | 78 +++++++
 tb/tb_noc_packetizer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/noc_packetizer_if.sv
// PE-request / router-output handshake bundle for noc_packetizer.
// master: PE + router side (drives requests, accepts packets); slave: the packetizer.
interface noc_packetizer_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned PAY_W = WIDTH - 2 * ADDR_W;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              pe_valid;
  logic              pe_ready;
  logic [ADDR_W-1:0] pe_dest;
  logic [PAY_W-1:0]  pe_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [LVL_W-1:0]  level;
  logic              self_drop;

  modport master (
    output pe_valid, pe_dest, pe_data, out_ready,
    input  pe_ready, out_valid, out_data, level, self_drop
  );

  modport slave (
    input  pe_valid, pe_dest, pe_data, out_ready,
    output pe_ready, out_valid, out_data, level, self_drop
  );
endinterface

// File: rtl/noc_packetizer.sv
// Network-interface packetizer: stamps PE requests with SRC_ADDR and buffers them in a FIFO toward the router.
// Optional macro NOC_PKT_SELF_DROP_EN discards self-addressed requests and pulses self_drop.
module noc_packetizer #(
  parameter int unsigned            WIDTH    = 32,
  parameter int unsigned            ADDR_W   = 3,
  parameter logic [ADDR_W-1:0]      SRC_ADDR = 3'd0,
  parameter int unsigned            DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  noc_packetizer_if.slave   bus
);
  localparam int unsigned PAY_W = WIDTH - 2 * ADDR_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic [WIDTH-1:0] pkt_c;

  // Handshake decodes depend only on registered occupancy.
  assign bus.pe_ready  = (level_q != LVL_W'(DEPTH));
  assign bus.out_valid = (level_q != LVL_W'(0));
  assign bus.out_data  = mem[rd_ptr];
  assign bus.level     = level_q;

  assign accept_c = bus.pe_valid && bus.pe_ready;
  assign pop_c    = bus.out_valid && bus.out_ready;
  assign pkt_c    = {bus.pe_dest, SRC_ADDR, PAY_W'(bus.pe_data)};

`ifdef NOC_PKT_SELF_DROP_EN
  logic is_self_c;
  logic self_drop_q;

  assign is_self_c     = (bus.pe_dest == SRC_ADDR);
  assign push_c        = accept_c && !is_self_c;
  assign bus.self_drop = self_drop_q;

  always_ff @(posedge clk) begin
    if (reset) self_drop_q <= 1'b0;
    else       self_drop_q <= accept_c && is_self_c;
  end
`else
  assign push_c        = accept_c;
  assign bus.self_drop = 1'b0;
`endif

  // Storage and write pointer; reset clears every entry so out_data reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= pkt_c;
      wr_ptr      <= wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer and occupancy; full/empty come from level, not pointer compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_packetizer.sv
// Scoreboard bench for noc_packetizer (SRC_ADDR=2, DEPTH=4); expected packets queued on accept, compared on pop.
module tb_noc_packetizer;
  localparam int unsigned   DEPTH = 4;
  localparam logic [2:0]    SRC   = 3'd2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_level;
  int   n_pops;
  logic [31:0] sb[$];

  noc_packetizer_if #(.WIDTH(32), .ADDR_W(3), .DEPTH(DEPTH)) bus ();

  noc_packetizer #(.WIDTH(32), .ADDR_W(3), .SRC_ADDR(SRC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks visible state against the model, updates the model for this edge, then advances one cycle.
  task automatic tick();
    logic sd;
    logic pop;
    logic push;
    sd   = 1'b0;
    pop  = bus.out_valid && bus.out_ready;
    push = 1'b0;
    check("level",     32'(bus.level),     32'(exp_level));
    check("out_valid", 32'(bus.out_valid), 32'(exp_level != 0));
    check("pe_ready",  32'(bus.pe_ready),  32'(exp_level != int'(DEPTH)));
    if (!reset) begin
      if (bus.pe_valid && bus.pe_ready) begin
`ifdef NOC_PKT_SELF_DROP_EN
        if (bus.pe_dest == SRC) sd = 1'b1;
        else push = 1'b1;
`else
        push = 1'b1;
`endif
      end
      if (pop) begin
        if (sb.size() == 0) check("pop_underflow", 32'(1), 32'(0));
        else begin
          check("pop_data", bus.out_data, sb.pop_front());
          n_pops++;
        end
      end else if (exp_level != 0 && sb.size() != 0) begin
        check("head_hold", bus.out_data, sb[0]);
      end
      if (push) sb.push_back({bus.pe_dest, SRC, bus.pe_data});
      exp_level = exp_level + (push ? 1 : 0) - ((pop && exp_level != 0) ? 1 : 0);
    end else begin
      sb.delete();
      exp_level = 0;
    end
    @(posedge clk);
    #1;
    check("self_drop", 32'(bus.self_drop), 32'(sd));
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic [25:0] p, input logic r);
    bus.pe_valid  = v;
    bus.pe_dest   = d;
    bus.pe_data   = p;
    bus.out_ready = r;
  endtask

  initial begin
    logic [31:0] held;
    int pops0;
    n_checks  = 0;
    n_fail    = 0;
    exp_level = 0;
    n_pops    = 0;
    reset     = 1'b1;
    drive(1'b1, 3'd1, 26'h123, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 3'd0, 26'h0, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_level", 32'(bus.level), 32'(0));

    // Single packet: one-cycle latency, fixed expected encoding.
    drive(1'b1, 3'd5, 26'h0ABCDE, 1'b0);
    tick();
    drive(1'b0, 3'd0, 26'h0, 1'b0);
    check("single_pkt", bus.out_data, 32'hA80ABCDE);
    check("single_valid", 32'(bus.out_valid), 32'(1));
    bus.out_ready = 1'b1;
    tick();
    check("single_empty", 32'(bus.out_valid), 32'(0));

    // Fill to full with the router stalled, hold off a fifth, then drain.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i + 4), 26'(32'h100 + i), 1'b0);
      tick();
    end
    check("full_ready", 32'(bus.pe_ready), 32'(0));
    drive(1'b1, 3'd7, 26'h3FFFFFF, 1'b0);
    tick();
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) bus.pe_valid = 1'b0;
      tick();
    end
    check("drain_level", 32'(bus.level), 32'(0));

    // Back-pressure: head must not change while stalled.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd3, 26'(32'h2000 + i), 1'b0);
      tick();
    end
    bus.pe_valid = 1'b0;
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable", bus.out_data, held);
    end

    // Sustained push+pop at level 2: no bubbles, level constant.
    pops0 = n_pops;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'(i % 2 == 0 ? 1 : 6), 26'($urandom), 1'b1);
      tick();
    end
    check("stream_pops", 32'(n_pops - pops0), 32'(20));
    check("stream_level", 32'(bus.level), 32'(2));

    // Reset mid-operation with level 3 and a push in the same cycle.
    drive(1'b1, 3'd4, 26'h55, 1'b0);
    tick();
    check("pre_rst_level", 32'(bus.level), 32'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 3'd0, 26'h0, 1'b0);
    check("mid_rst_level", 32'(bus.level), 32'(0));
    check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
    check("mid_rst_data", bus.out_data, 32'h0);
    check("mid_rst_ready", 32'(bus.pe_ready), 32'(1));

    // Self-addressed request.
    drive(1'b1, SRC, 26'h777, 1'b0);
    tick();
    bus.pe_valid = 1'b0;
`ifdef NOC_PKT_SELF_DROP_EN
    check("self_level", 32'(bus.level), 32'(0));
    check("self_pulse", 32'(bus.self_drop), 32'(1));
`else
    check("self_level", 32'(bus.level), 32'(1));
    check("self_pkt", bus.out_data, {SRC, SRC, 26'h777});
`endif
    tick();
    check("self_pulse_end", 32'(bus.self_drop), 32'(0));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 26'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(1'b0, 3'd0, 26'h0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("final_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
